// File: rtl/spi_dac_writer.sv
// Write-only SPI master for a serial DAC: sends one {ctrl, data} frame, MSB first,
// with cs active-low, sclk idling high and the device sampling din on sclk rises.
module spi_dac_writer #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 12,
  parameter int HALF   = 2,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              sclk,
  output logic              din
);

  localparam int N  = CTRL_W + DATA_W;
  localparam int CW = $clog2((HALF > GAP ? HALF : GAP) + 1);
  localparam int BW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          din_q, din_d;

  logic [N-1:0]  frame_in;
  logic          half_end;
  logic          gap_end;
  logic          last_bit;

  assign frame_in = {ctrl_in, data_in};
  assign half_end = (cnt_q == CW'(HALF - 1));
  assign gap_end  = (cnt_q == CW'(GAP - 1));
  assign last_bit = (bit_q == BW'(N - 1));

  // The shift register's MSB is always the bit on din; it only shifts on a
  // HIGH->LOW transition, so the LEAD->LOW fall keeps the first bit in place.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    din_d   = din_q;

    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          sr_d    = frame_in;
          din_d   = frame_in[N-1];
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_LEAD;
        end
      end

      S_LEAD: begin
        if (half_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_LOW: begin
        if (half_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (half_end) begin
          cnt_d = '0;
          if (last_bit) begin
            cs_d    = 1'b1;
            din_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + 1'b1;
            sr_d    = {sr_q[N-2:0], 1'b0};
            din_d   = sr_q[N-2];
            sclk_d  = 1'b0;
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // The done cycle is the first of the GAP cycles with cs high.
      S_GAP: begin
        if (gap_end) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        din_d   = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign cs    = cs_q;
  assign sclk  = sclk_q;
  assign din   = din_q;

endmodule

// File: tb/tb_spi_dac_writer.sv
// Directed bench for spi_dac_writer: a default instance (HALF=2, GAP=4) and a
// fast instance (HALF=1, GAP=1), each watched by a DAC-side frame monitor.
module tb_spi_dac_writer;

  logic clk;
  logic rst;

  logic [3:0]  ctrl_a, ctrl_b;
  logic [11:0] data_a, data_b;
  logic        valid_a, valid_b;
  logic        ready_a, busy_a, done_a, cs_a, sclk_a, din_a;
  logic        ready_b, busy_b, done_b, cs_b, sclk_b, din_b;

  int checks;
  int errors;

  spi_dac_writer #(.CTRL_W(4), .DATA_W(12), .HALF(2), .GAP(4)) dut_a (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_a), .data_in(data_a), .valid(valid_a),
    .ready(ready_a), .busy(busy_a), .done(done_a), .cs(cs_a), .sclk(sclk_a), .din(din_a)
  );

  spi_dac_writer #(.CTRL_W(4), .DATA_W(12), .HALF(1), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_b), .data_in(data_b), .valid(valid_b),
    .ready(ready_b), .busy(busy_b), .done(done_b), .cs(cs_b), .sclk(sclk_b), .din(din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DAC-side monitors: shift din in on every sclk rise seen while cs is low and
  // log each completed cs-low window along with its timing.
  int          cyc_a = 0, rises_a = 0, cslow_a = 0, dones_a = 0, done_bad_a = 0, tog_bad_a = 0;
  int          fall_cyc_a = 0, rise_cyc_a = 0, ready_cyc_a = 0, gap_a = 0, a2a_a = 0;
  logic [15:0] rx_a = '0;
  logic        pcs_a = 1'b1, psclk_a = 1'b1, pready_a = 1'b0;
  logic [15:0] frames_a[$];
  int          cslen_a[$];
  int          nrise_a[$];

  always @(negedge clk) begin
    cyc_a++;
    if (pcs_a && !cs_a) begin
      gap_a      = cyc_a - rise_cyc_a;
      a2a_a      = cyc_a - fall_cyc_a;
      fall_cyc_a = cyc_a;
      rx_a       = '0;
      rises_a    = 0;
      cslow_a    = 0;
    end
    if (cs_a === 1'b0) begin
      cslow_a++;
      if (sclk_a && !psclk_a) begin
        rx_a = {rx_a[14:0], din_a};
        rises_a++;
      end
    end else if (cs_a === 1'b1 && sclk_a !== 1'b1) begin
      tog_bad_a++;
    end
    if (!pcs_a && cs_a) begin
      frames_a.push_back(rx_a);
      cslen_a.push_back(cslow_a);
      nrise_a.push_back(rises_a);
      rise_cyc_a = cyc_a;
    end
    if (done_a === 1'b1) begin
      dones_a++;
      if (!(cs_a && !pcs_a)) done_bad_a++;
    end
    if (ready_a && !pready_a) ready_cyc_a = cyc_a;
    pcs_a    = cs_a;
    psclk_a  = sclk_a;
    pready_a = ready_a;
  end

  int          cyc_b = 0, rises_b = 0, cslow_b = 0, dones_b = 0, tog_bad_b = 0;
  int          fall_cyc_b = 0, a2a_b = 0;
  logic [15:0] rx_b = '0;
  logic        pcs_b = 1'b1, psclk_b = 1'b1;
  logic [15:0] frames_b[$];
  int          cslen_b[$];

  always @(negedge clk) begin
    cyc_b++;
    if (pcs_b && !cs_b) begin
      a2a_b      = cyc_b - fall_cyc_b;
      fall_cyc_b = cyc_b;
      rx_b       = '0;
      rises_b    = 0;
      cslow_b    = 0;
    end
    if (cs_b === 1'b0) begin
      cslow_b++;
      if (sclk_b && !psclk_b) begin
        rx_b = {rx_b[14:0], din_b};
        rises_b++;
      end
    end else if (cs_b === 1'b1 && sclk_b !== 1'b1) begin
      tog_bad_b++;
    end
    if (!pcs_b && cs_b) begin
      frames_b.push_back(rx_b);
      cslen_b.push_back(cslow_b);
    end
    if (done_b === 1'b1) dones_b++;
    pcs_b   = cs_b;
    psclk_b = sclk_b;
  end

  task automatic clear_mon();
    frames_a.delete();
    cslen_a.delete();
    nrise_a.delete();
    frames_b.delete();
    cslen_b.delete();
    dones_a    = 0;
    done_bad_a = 0;
    dones_b    = 0;
  endtask

  // Bounded wait for the selected instance to be idle with cs high.
  task automatic wait_ready(input bit inst_b, input int limit, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = inst_b ? (ready_b === 1'b1 && cs_b === 1'b1) : (ready_a === 1'b1 && cs_a === 1'b1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s timeout: ready not seen within %0d cycles", tag, limit);
    end
  endtask

  task automatic send_a(input logic [3:0] c, input logic [11:0] d);
    @(negedge clk);
    ctrl_a  = c;
    data_a  = d;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {cs_a, sclk_a, din_a, ready_a, busy_a, done_a};
      checks++;
      if (obs !== 6'b110100) begin
        errors++;
        $display("[TB] FAIL reset_a cyc%0d: got %b want 110100", i, obs);
      end
      obs = {cs_b, sclk_b, din_b, ready_b, busy_b, done_b};
      checks++;
      if (obs !== 6'b110100) begin
        errors++;
        $display("[TB] FAIL reset_b cyc%0d: got %b want 110100", i, obs);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    clear_mon();
    send_a(4'h3, 12'hA5C);
    wait_ready(1'b0, 200, "single");
    repeat (3) @(negedge clk);
    checks++;
    if (frames_a.size() != 1 || frames_a[0] !== 16'h3A5C) begin
      errors++;
      $display("[TB] FAIL single_frame: got %0d frames, first %h, want 1 x 3a5c",
               frames_a.size(), frames_a.size() > 0 ? frames_a[0] : 16'hxxxx);
    end
    checks++;
    if (nrise_a.size() != 1 || nrise_a[0] != 16) begin
      errors++;
      $display("[TB] FAIL single_rises: got %0d want 16", nrise_a.size() > 0 ? nrise_a[0] : -1);
    end
    checks++;
    if (cslen_a.size() != 1 || cslen_a[0] != 66) begin
      errors++;
      $display("[TB] FAIL single_cs_low: got %0d want 66", cslen_a.size() > 0 ? cslen_a[0] : -1);
    end
    checks++;
    if (dones_a != 1 || done_bad_a != 0) begin
      errors++;
      $display("[TB] FAIL single_done: got %0d pulses (%0d misaligned) want 1 aligned with cs rise",
               dones_a, done_bad_a);
    end
    checks++;
    if (ready_cyc_a - rise_cyc_a != 4) begin
      errors++;
      $display("[TB] FAIL single_ready_delay: got %0d want 4", ready_cyc_a - rise_cyc_a);
    end
  endtask

  // cs stays high for the GAP cycles plus the idle cycle where the next word is accepted.
  task automatic test_back_to_back();
    clear_mon();
    @(negedge clk);
    ctrl_a  = 4'h0;
    data_a  = 12'hFFF;
    valid_a = 1'b1;
    @(negedge clk);
    ctrl_a = 4'h0;
    data_a = 12'h000;
    wait_ready(1'b0, 200, "b2b_first");
    @(negedge clk);
    valid_a = 1'b0;
    wait_ready(1'b0, 200, "b2b_second");
    repeat (3) @(negedge clk);
    checks++;
    if (frames_a.size() != 2 || frames_a[0] !== 16'h0FFF || frames_a[1] !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL b2b_frames: got %0d frames, want 0fff then 0000", frames_a.size());
    end
    checks++;
    if (gap_a != 5) begin
      errors++;
      $display("[TB] FAIL b2b_cs_high: got %0d want 5", gap_a);
    end
    checks++;
    if (a2a_a != 71) begin
      errors++;
      $display("[TB] FAIL b2b_accept_period: got %0d want 71", a2a_a);
    end
  endtask

  task automatic test_stability();
    clear_mon();
    send_a(4'hA, 12'h123);
    for (int i = 0; i < 40; i++) begin
      ctrl_a  = 4'($urandom);
      data_a  = 12'($urandom);
      valid_a = (i == 15);
      @(negedge clk);
    end
    valid_a = 1'b0;
    wait_ready(1'b0, 200, "stability");
    repeat (10) @(negedge clk);
    checks++;
    if (frames_a.size() != 1 || frames_a[0] !== 16'hA123) begin
      errors++;
      $display("[TB] FAIL stability_frame: got %0d frames, first %h, want 1 x a123",
               frames_a.size(), frames_a.size() > 0 ? frames_a[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    bit         hit;
    clear_mon();
    send_a(4'hC, 12'h3A5);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (rises_a == 7 && cs_a === 1'b0);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL midreset_seventh_rise: not reached, rises %0d want 7", rises_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs = {cs_a, sclk_a, din_a, ready_a, busy_a, done_a};
    checks++;
    if (obs !== 6'b110100) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b want 110100", obs);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dones_a != 0) begin
      errors++;
      $display("[TB] FAIL midreset_no_done: got %0d pulses want 0", dones_a);
    end
    clear_mon();
    send_a(4'h0, 12'h800);
    wait_ready(1'b0, 200, "midreset_next");
    repeat (3) @(negedge clk);
    checks++;
    if (frames_a.size() != 1 || frames_a[0] !== 16'h0800 || dones_a != 1) begin
      errors++;
      $display("[TB] FAIL midreset_next_frame: got %0d frames, first %h, %0d dones, want 1 x 0800",
               frames_a.size(), frames_a.size() > 0 ? frames_a[0] : 16'hxxxx, dones_a);
    end
  endtask

  task automatic test_fast();
    clear_mon();
    @(negedge clk);
    ctrl_b  = 4'h5;
    data_b  = 12'h555;
    valid_b = 1'b1;
    @(negedge clk);
    wait_ready(1'b1, 100, "fast_first");
    @(negedge clk);
    valid_b = 1'b0;
    wait_ready(1'b1, 100, "fast_second");
    repeat (3) @(negedge clk);
    checks++;
    if (frames_b.size() != 2 || frames_b[0] !== 16'h5555 || frames_b[1] !== 16'h5555) begin
      errors++;
      $display("[TB] FAIL fast_frames: got %0d frames, want 2 x 5555", frames_b.size());
    end
    checks++;
    if (cslen_b.size() != 2 || cslen_b[0] != 33 || cslen_b[1] != 33) begin
      errors++;
      $display("[TB] FAIL fast_cs_low: got %0d want 33", cslen_b.size() > 0 ? cslen_b[0] : -1);
    end
    checks++;
    if (a2a_b != 35) begin
      errors++;
      $display("[TB] FAIL fast_accept_period: got %0d want 35", a2a_b);
    end
    checks++;
    if (dones_b != 2) begin
      errors++;
      $display("[TB] FAIL fast_done: got %0d want 2", dones_b);
    end
  endtask

  task automatic test_idle_sclk();
    checks++;
    if (tog_bad_a != 0 || tog_bad_b != 0) begin
      errors++;
      $display("[TB] FAIL sclk_idle_high: got %0d/%0d low cycles with cs high, want 0/0",
               tog_bad_a, tog_bad_b);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    ctrl_a  = '0;
    data_a  = '0;
    ctrl_b  = '0;
    data_b  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stability();
    test_reset_mid();
    test_fast();
    test_idle_sclk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
